// File: rtl/zprize_mul_pkg.sv
// Shared types and helpers for the streaming multiplier.
package zprize_mul_pkg;

   // Widest product the slice helper handles (1024 x 1024).
   localparam int unsigned MUL_MAXW = 2048;

   typedef enum logic [1:0] {
      MUL_FULL = 2'd0,
      MUL_LO   = 2'd1,
      MUL_HI   = 2'd2
   } mul_mode_e;

   // Output FIFO depth: pipeline depth plus two so a full pipeline never stalls.
   function automatic int unsigned mul_fd(input int unsigned lat);
      return lat + 32'd2;
   endfunction

   // Select the result view of a w0 x w1 product; the reserved mode falls back to the full product.
   function automatic logic [MUL_MAXW-1:0] mul_slice(input logic [MUL_MAXW-1:0] prod,
                                                     input int unsigned        w0,
                                                     input int unsigned        w1,
                                                     input logic [1:0]         mode);
      logic [MUL_MAXW-1:0] lo_mask;
      logic [MUL_MAXW-1:0] full_mask;
      logic [MUL_MAXW-1:0] res;
      lo_mask   = (MUL_MAXW'(1) << w0) - MUL_MAXW'(1);
      full_mask = (MUL_MAXW'(1) << (w0 + w1)) - MUL_MAXW'(1);
      case (mode)
         MUL_LO:  res = prod & lo_mask;
         MUL_HI:  res = (prod & full_mask) >> w0;
         default: res = prod & full_mask;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/zprize_mul_stream_fifo.sv
// First-word-fall-through FIFO with pointers wrapping at an arbitrary depth.
module zprize_mul_stream_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int unsigned     PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     CNTW = $clog2(DEPTH + 1);
   localparam logic [PTRW-1:0] LAST = PTRW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             pop;

   assign pop       = rd_en_i && valid_q;
   assign valid_o   = valid_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Next pointers, occupancy and registered not-empty flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en_i) begin
         wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTRW'(1);
      end
      case ({wr_en_i, pop})
         2'b10:   cnt_d = cnt_q + CNTW'(1);
         2'b01:   cnt_d = cnt_q - CNTW'(1);
         default: cnt_d = cnt_q;
      endcase
      valid_d = (cnt_d != '0);
   end

   // Control state; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
      end
   end

   // Storage array, data only, not reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/zprize_mul_stream.sv
// Streaming unsigned multiplier: fixed-latency pipeline feeding a credit-guarded output FIFO.
// Optional result-select port enabled by defining ZPRIZE_MUL_STREAM_MODE_EN.
module zprize_mul_stream import zprize_mul_pkg::*; #(
   parameter int unsigned W0  = 384,
   parameter int unsigned W1  = 384,
   parameter int unsigned M   = 32,
   parameter int unsigned LAT = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W0-1:0]    in0,
   input  logic [W1-1:0]    in1,
   input  logic [M-1:0]     m_i,
`ifdef ZPRIZE_MUL_STREAM_MODE_EN
   input  logic [1:0]       mode_i,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W0+W1-1:0] out0,
   output logic [M-1:0]     m_o
);

   localparam int unsigned PW = W0 + W1;
   localparam int unsigned FD = mul_fd(LAT);
   localparam int unsigned CW = $clog2(FD + 1);

   logic          accept;
   logic          pop;
   logic [CW-1:0] credit_q, credit_d;
   logic          in_ready_q, in_ready_d;

   logic [LAT-1:0] vld_q;
   logic [W0-1:0]  op0_q;
   logic [W1-1:0]  op1_q;
   logic [M-1:0]   meta_q [LAT];
   logic [PW-1:0]  res_q  [1:LAT-1];
   logic [PW-1:0]  prod_c;
   logic [PW-1:0]  res_c;
`ifdef ZPRIZE_MUL_STREAM_MODE_EN
   logic [1:0]     mode_s0_q;
`endif

   logic [PW+M-1:0] fifo_rd;

   assign accept   = in_valid && in_ready_q;
   assign pop      = out_valid && out_ready;
   assign in_ready = in_ready_q;

   // Multiply between stage 0 and stage 1, applying the result view there.
   assign prod_c = PW'(op0_q) * PW'(op1_q);
`ifdef ZPRIZE_MUL_STREAM_MODE_EN
   assign res_c = PW'(mul_slice(MUL_MAXW'(prod_c), W0, W1, mode_s0_q));
`else
   assign res_c = prod_c;
`endif

   // Credits cover everything in flight or buffered; ready is a registered function of them.
   always_comb begin
      credit_d = credit_q;
      case ({accept, pop})
         2'b10:   credit_d = credit_q + CW'(1);
         2'b01:   credit_d = credit_q - CW'(1);
         default: credit_d = credit_q;
      endcase
      in_ready_d = (credit_d < CW'(FD));
   end

   // Control registers: credits, ready flag and pipeline valid chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_q   <= '0;
         in_ready_q <= 1'b1;
         vld_q      <= '0;
      end else begin
         credit_q   <= credit_d;
         in_ready_q <= in_ready_d;
         vld_q      <= {vld_q[LAT-2:0], accept};
      end
   end

   // Pipeline payload: operands captured on accept, product and metadata shifted each cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         op0_q     <= in0;
         op1_q     <= in1;
         meta_q[0] <= m_i;
`ifdef ZPRIZE_MUL_STREAM_MODE_EN
         mode_s0_q <= mode_i;
`endif
      end
      res_q[1] <= res_c;
      for (int unsigned k = 2; k < LAT; k++) begin
         res_q[k] <= res_q[k-1];
      end
      for (int unsigned k = 1; k < LAT; k++) begin
         meta_q[k] <= meta_q[k-1];
      end
   end

   zprize_mul_stream_fifo #(
      .WIDTH (PW + M),
      .DEPTH (FD)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .wr_en_i   (vld_q[LAT-1]),
      .wr_data_i ({res_q[LAT-1], meta_q[LAT-1]}),
      .rd_en_i   (out_ready),
      .valid_o   (out_valid),
      .rd_data_o (fifo_rd)
   );

   assign out0 = fifo_rd[PW+M-1:M];
   assign m_o  = fifo_rd[M-1:0];

endmodule

// File: doc/zprize_mul_stream.md
ZPRIZE_MUL_STREAM -- requirements
Module: zprize_mul_stream

Interface
REQ-001 Parameter W0, default 384, in0 operand width in bits (1..1024).
REQ-002 Parameter W1, default 384, in1 operand width in bits (1..1024).
REQ-003 Parameter M, default 32, sideband metadata width in bits (>=1).
REQ-004 Parameter LAT, default 5, multiplier pipeline depth in cycles (>=2).
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  in0/in1/m_i/mode_i carry a transaction.
REQ-008 in_ready  output  1  block accepts a transaction this cycle.
REQ-009 in0  input  W0  unsigned multiplicand.
REQ-010 in1  input  W1  unsigned multiplier.
REQ-011 m_i  input  M  metadata, passed through unmodified.
REQ-012 mode_i  input  2  result select: 0 full product, 1 low W0 bits, 2 high W1 bits, 3 reserved (treated as 0); present only when the mode feature is compiled in.
REQ-013 out_valid  output  1  out0/m_o hold a result.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 out0  output  W0+W1  result, zero-extended per mode.
REQ-016 m_o  output  M  metadata paired with out0.

Function
REQ-017 Accept a transaction iff in_valid && in_ready in the same cycle (the "accept" event).
REQ-018 Pipeline: LAT-stage register chain carrying valid, product and metadata; product may be retimed across stages; pipeline never stalls.
REQ-019 Output FIFO: depth FD = LAT+2, first-word-fall-through, stores {result, metadata}.
REQ-020 Credit counter: in-flight pipeline entries + FIFO occupancy, range 0..FD; +1 on accept, -1 on pop (out_valid && out_ready); both in one cycle leaves it unchanged.
REQ-021 in_ready = 1 iff counter < FD; combinational from registered state only, never from in_valid or out_ready.
REQ-022 Result enters the FIFO exactly LAT cycles after accept; earliest out_valid is LAT+1 cycles after accept... with FIFO empty, out_valid rises in the cycle after the result is written (total latency LAT+1).
REQ-023 Order preserved: results and metadata leave in acceptance order; throughput one per cycle when out_ready is held high.
REQ-024 out0 and m_o stable while out_valid && !out_ready.
REQ-025 FIFO full and pop in the same cycle: write and pop both proceed; overflow is impossible by REQ-021.
REQ-026 Mode 1 out0 = {W1 zeros, product[W0-1:0]}; mode 2 out0 = {W0 zeros, product[W0+W1-1:W0]}.
REQ-027 Write and read pointers wrap modulo FD, with FD not a power of two.

Reset
REQ-028 On rst low, asynchronously: out_valid=0, credit counter=0, FIFO pointers=0, all pipeline valid bits=0; in_ready=1 from the first cycle after release.
REQ-029 Reset mid-operation discards all in-flight and buffered transactions; out0/m_o data registers need not be reset.

Configuration
REQ-030 Macro ZPRIZE_MUL_STREAM_MODE_EN: defined -> mode_i port exists and REQ-026 applies; undefined -> no mode_i port and out0 is always the full product.

Structure
REQ-031 Shared package zprize_mul_pkg holds: mode enumeration (MUL_FULL, MUL_LO, MUL_HI), the FD derivation function and the result-slice function.
REQ-032 One sub-module, zprize_mul_stream_fifo (parametrised width and depth, FWFT, async active-low reset); the multiplier pipeline is inline.

Verification
REQ-033 W0=W1=8, LAT=3: in0=0xFF, in1=0xFF, m_i=0x5 -> out0=0xFE01, m_o=0x5, out_valid 4 cycles after accept.
REQ-034 out_ready=0, 10 back-to-back valids -> exactly FD=5 accepts, then in_ready=0; releasing out_ready drains 5 results in order.
REQ-035 Push and pop in the same cycle with the FIFO full -> counter stays 5, no loss or duplication, pointer wrap exercised.
REQ-036 MODE_EN, W0=W1=8: 0xFF*0x02 with mode 1 -> 0x00FE; mode 2 -> 0x0001; mode 3 -> 0x01FE.
REQ-037 rst low with 3 in flight and 2 buffered -> out_valid=0 immediately, no stale result after release, in_ready=1.
REQ-038 Random 10k transactions, random valid/ready, W0=384, W1=384, LAT=5 -> every result matches the reference product and order, and in_ready never depends combinationally on in_valid.
